// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between two writeback requesters, the arbiter and the register file.
interface regfile_write_arbiter_if;
  logic        req0Valid;
  logic [2:0]  req0Num;
  logic [15:0] req0Data;
  logic        req0Ready;
  logic        req1Valid;
  logic [2:0]  req1Num;
  logic [15:0] req1Data;
  logic        req1Ready;
  logic        regWrite;
  logic [2:0]  regWriteNum;
  logic [15:0] writeData;
  logic        zeroErr;

  modport slave (
    input  req0Valid, req0Num, req0Data,
    input  req1Valid, req1Num, req1Data,
    output req0Ready, req1Ready,
    output regWrite, regWriteNum, writeData, zeroErr
  );

  modport master (
    output req0Valid, req0Num, req0Data,
    output req1Valid, req1Num, req1Data,
    input  req0Ready, req1Ready,
    input  regWrite, regWriteNum, writeData, zeroErr
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter, round-robin by default; defining
// ARB_FIXED_PRIO_EN makes requester 0 always win and removes the priority pointer.
module regfile_write_arbiter (
  input  logic                           clk,
  input  logic                           rst_n,
  regfile_write_arbiter_if.slave         bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t      state_r;
  state_t      stateNext_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        xfer_s;
  logic [2:0]  xferNum_s;
  logic [15:0] xferData_s;
  logic        xferNonZero_s;
  logic [2:0]  regWriteNum_r;
  logic [15:0] writeData_r;
  logic        zeroErr_r;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority grant: requester 0 always wins a contest
  always_comb begin
    grant0_s = bus.req0Valid;
    grant1_s = bus.req1Valid & ~bus.req0Valid;
  end
`else
  logic prioPtr_r;

  // Round-robin grant: contest resolved by the priority pointer
  always_comb begin
    grant0_s = bus.req0Valid & (~bus.req1Valid | ~prioPtr_r);
    grant1_s = bus.req1Valid & (~bus.req0Valid |  prioPtr_r);
  end

  // Pointer moves to the loser after every grant, holds otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prioPtr_r <= 1'b0;
    end else if (grant0_s) begin
      prioPtr_r <= 1'b1;
    end else if (grant1_s) begin
      prioPtr_r <= 1'b0;
    end else begin
      prioPtr_r <= prioPtr_r;
    end
  end
`endif

  // Ready is the grant, forced low while reset is held
  always_comb begin
    bus.req0Ready = grant0_s & rst_n;
    bus.req1Ready = grant1_s & rst_n;
  end

  // Select the granted transfer
  always_comb begin
    xfer_s     = 1'b0;
    xferNum_s  = 3'd0;
    xferData_s = 16'd0;
    if (grant0_s) begin
      xfer_s     = 1'b1;
      xferNum_s  = bus.req0Num;
      xferData_s = bus.req0Data;
    end else if (grant1_s) begin
      xfer_s     = 1'b1;
      xferNum_s  = bus.req1Num;
      xferData_s = bus.req1Data;
    end else begin
      xfer_s     = 1'b0;
    end
    xferNonZero_s = xfer_s & (xferNum_s != 3'd0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next state: WRITE only for a transfer to a real (nonzero) register
  always_comb begin
    stateNext_s = IDLE;
    case (state_r)
      IDLE:    stateNext_s = xferNonZero_s ? WRITE : IDLE;
      WRITE:   stateNext_s = xferNonZero_s ? WRITE : IDLE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Registered write address/data hold across idle and r0 cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regWriteNum_r <= 3'd0;
      writeData_r   <= 16'd0;
      zeroErr_r     <= 1'b0;
    end else begin
      zeroErr_r <= xfer_s & (xferNum_s == 3'd0);
      if (xferNonZero_s) begin
        regWriteNum_r <= xferNum_s;
        writeData_r   <= xferData_s;
      end else begin
        regWriteNum_r <= regWriteNum_r;
        writeData_r   <= writeData_r;
      end
    end
  end

  assign bus.regWrite    = (state_r == WRITE);
  assign bus.regWriteNum = regWriteNum_r;
  assign bus.writeData   = writeData_r;
  assign bus.zeroErr     = zeroErr_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expectations follow ARB_FIXED_PRIO_EN when defined.
module tb_regfile_write_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v0, input logic [2:0] n0, input logic [15:0] d0,
                       input logic v1, input logic [2:0] n1, input logic [15:0] d1);
    @(negedge clk);
    bus.req0Valid = v0;
    bus.req0Num   = n0;
    bus.req0Data  = d0;
    bus.req1Valid = v1;
    bus.req1Num   = n1;
    bus.req1Data  = d1;
    #1;
  endtask

  task automatic edgeStep();
    @(posedge clk);
    #1;
  endtask

  task automatic chkOut(input string tag, input logic w, input logic [2:0] n,
                        input logic [15:0] d, input logic z);
    chk({tag, "_regWrite"}, {31'd0, bus.regWrite}, {31'd0, w});
    chk({tag, "_regWriteNum"}, {29'd0, bus.regWriteNum}, {29'd0, n});
    chk({tag, "_writeData"}, {16'd0, bus.writeData}, {16'd0, d});
    chk({tag, "_zeroErr"}, {31'd0, bus.zeroErr}, {31'd0, z});
  endtask

  logic        expG0 [4];
  logic [2:0]  expNum [4];
  logic [15:0] expDat [4];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req0Valid = 1'b0; bus.req0Num = 3'd0; bus.req0Data = 16'd0;
    bus.req1Valid = 1'b0; bus.req1Num = 3'd0; bus.req1Data = 16'd0;

    // Reset: outputs cleared, ready held low even with requests present
    drive(1'b1, 3'd3, 16'h1234, 1'b1, 3'd2, 16'h5555);
    chk("rst_ready0", {31'd0, bus.req0Ready}, 32'd0);
    chk("rst_ready1", {31'd0, bus.req1Ready}, 32'd0);
    edgeStep();
    chkOut("rst", 1'b0, 3'd0, 16'd0, 1'b0);

    // Scenario 1: first cycle out of reset, req0 (r3, 0x1234)
    drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0);
    rst_n = 1'b1;
    #1;
    chk("s1_ready0", {31'd0, bus.req0Ready}, 32'd1);
    chk("s1_ready1", {31'd0, bus.req1Ready}, 32'd0);
    edgeStep();
    chkOut("s1", 1'b1, 3'd3, 16'h1234, 1'b0);

    // Idle: regWrite drops, address/data hold
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    chk("idle_ready0", {31'd0, bus.req0Ready}, 32'd0);
    edgeStep();
    chkOut("idle", 1'b0, 3'd3, 16'h1234, 1'b0);

    // Re-reset so the pointer favours requester 0 again
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    rst_n = 1'b0;
    edgeStep();
    chkOut("rst2", 1'b0, 3'd0, 16'd0, 1'b0);

    // Scenario 2/3: both valid for four cycles
`ifdef ARB_FIXED_PRIO_EN
    expG0  = '{1'b1, 1'b1, 1'b1, 1'b1};
    expNum = '{3'd1, 3'd1, 3'd1, 3'd1};
    expDat = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
`else
    expG0  = '{1'b1, 1'b0, 1'b1, 1'b0};
    expNum = '{3'd1, 3'd2, 3'd1, 3'd2};
    expDat = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
      rst_n = 1'b1;
      #1;
      chk($sformatf("both%0d_ready0", i), {31'd0, bus.req0Ready}, {31'd0, expG0[i]});
      chk($sformatf("both%0d_ready1", i), {31'd0, bus.req1Ready}, {31'd0, ~expG0[i]});
      edgeStep();
      chkOut($sformatf("both%0d", i), 1'b1, expNum[i], expDat[i], 1'b0);
    end

    // Scenario 4: write to r0 accepted, no regWrite, one-cycle zeroErr
    drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 16'hFFFF);
    chk("r0_ready1", {31'd0, bus.req1Ready}, 32'd1);
    edgeStep();
    chkOut("r0", 1'b0, expNum[3], expDat[3], 1'b1);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    edgeStep();
    chkOut("r0_after", 1'b0, expNum[3], expDat[3], 1'b0);

    // Scenario 6: same register back to back, grant order preserved
    drive(1'b1, 3'd4, 16'h0001, 1'b0, 3'd0, 16'd0);
    chk("b2b_ready0", {31'd0, bus.req0Ready}, 32'd1);
    edgeStep();
    chkOut("b2b_first", 1'b1, 3'd4, 16'h0001, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 16'h0002);
    chk("b2b_ready1", {31'd0, bus.req1Ready}, 32'd1);
    edgeStep();
    chkOut("b2b_second", 1'b1, 3'd4, 16'h0002, 1'b0);

    // Scenario 5: accepted write discarded by reset at the capturing edge
    drive(1'b1, 3'd5, 16'h0042, 1'b0, 3'd0, 16'd0);
    chk("rstx_ready0_pre", {31'd0, bus.req0Ready}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_ready0_rst", {31'd0, bus.req0Ready}, 32'd0);
    edgeStep();
    chkOut("rstx", 1'b0, 3'd0, 16'd0, 1'b0);
    drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    rst_n = 1'b1;
    edgeStep();
    chkOut("rstx_after", 1'b0, 3'd0, 16'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
